sine_dds: RTL

- Direct digital synthesis (DDS) sine source for the sine-wave project.
- Sits directly upstream of the 12-bit DAC model: `data_out` drives its `I_data` and `data_valid` drives its `en`, on the same `clk`.
- Uses a phase accumulator, a sample-rate divider and a quarter-wave LUT.
- Produces offset-binary 12-bit samples, with midscale 0x800 representing Vref/2.

---
 rtl/sine_pkg.sv | 36 +++
 rtl/sine_dds_if.sv | 23 ++
 rtl/sine_qlut.sv | 19 +
 rtl/sine_dds.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared types and constants for the sine DDS, including the constant function
// that builds the quarter-wave magnitude table at elaboration time.
package sine_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int DATA_W    = 12;
  localparam int MAG_W     = DATA_W - 1;
  localparam int QLUT_AW   = 8;
  localparam int LUT_DEPTH = 256;
  localparam logic [DATA_W-1:0] MIDSCALE = 12'h800;

  // pi scaled by 2^60; the table is computed in 128-bit fixed point so rounding matches real sin()
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  function automatic logic [LUT_DEPTH*MAG_W-1:0] gen_qlut();
    logic [LUT_DEPTH*MAG_W-1:0] tbl;
    logic [127:0] x, x2, term, acc, scaled;
    tbl = '0;
    for (int a = 0; a < LUT_DEPTH; a++) begin
      x    = (PI_Q60 * 128'(2 * a + 1)) >> 10;
      x2   = (x * x) >> 60;
      term = x;
      acc  = x;
      for (int k = 1; k <= 12; k++) begin
        term = ((term * x2) >> 60) / 128'(2 * k * (2 * k + 1));
        if (k % 2 == 1) acc = acc - term;
        else            acc = acc + term;
      end
      scaled = (acc * 128'(2047) + (128'(1) << 59)) >> 60;
      tbl[a*MAG_W +: MAG_W] = MAG_W'(scaled);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sine_dds_if.sv
// Control and sample bundle for sine_dds; carries amp when SINE_AMP_EN is defined.
interface sine_dds_if #(
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 16,
  parameter int DATA_W  = 12
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] fcw;
  logic [DIV_W-1:0]   div;
  logic [DATA_W-1:0]  data_out;
  logic               data_valid;
  logic               busy;
`ifdef SINE_AMP_EN
  logic [DATA_W-1:0]  amp;

  modport master (output start, stop, fcw, div, amp, input  data_out, data_valid, busy);
  modport slave  (input  start, stop, fcw, div, amp, output data_out, data_valid, busy);
`else
  modport master (output start, stop, fcw, div, input  data_out, data_valid, busy);
  modport slave  (input  start, stop, fcw, div, output data_out, data_valid, busy);
`endif
endinterface

// File: rtl/sine_qlut.sv
// Quarter-wave sine magnitude ROM (256 x 11) with a registered read port.
module sine_qlut
  import sine_pkg::*;
(
  input  logic               clk,
  input  logic [QLUT_AW-1:0] addr,
  output logic [MAG_W-1:0]   mag
);
  localparam logic [LUT_DEPTH*MAG_W-1:0] QLUT = gen_qlut();

  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_q;

  always_comb mag_d = QLUT[int'(addr)*MAG_W +: MAG_W];

  always_ff @(posedge clk) mag_q <= mag_d;

  assign mag = mag_q;
endmodule

// File: rtl/sine_dds.sv
// Sine DDS: phase accumulator and sample divider feeding a quarter-wave pipeline.
// Optional SINE_AMP_EN adds a latched amplitude port and one scaling stage.
module sine_dds #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = sine_pkg::DATA_W,
  parameter int DIV_W   = 16
) (
  input logic       clk,
  input logic       rst,
  sine_dds_if.slave bus
);
  import sine_pkg::*;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [DIV_W-1:0]   count_q, count_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;

  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_neg_q, s1_neg_d;
  logic [LUT_AW-1:0]  s1_addr_q, s1_addr_d;
  logic               s2_valid_q, s2_valid_d;
  logic               s2_neg_q, s2_neg_d;
  logic [MAG_W-1:0]   s2_mag;
  logic               fin_valid, fin_neg;
  logic [MAG_W-1:0]   fin_mag;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               pipe_busy;
`ifdef SINE_AMP_EN
  logic [DATA_W-1:0]  amp_q, amp_d;
  logic               s3a_valid_q, s3a_valid_d;
  logic               s3a_neg_q, s3a_neg_d;
  logic [MAG_W-1:0]   s3a_mag_q, s3a_mag_d;

  assign pipe_busy = s1_valid_q | s2_valid_q | s3a_valid_q | data_valid_q;
`else
  assign pipe_busy = s1_valid_q | s2_valid_q | data_valid_q;
`endif

  // Divider count of zero means "tick now"; stop suppresses the tick in its own cycle.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fcw_d   = fcw_q;
    count_d = count_q;
    div_d   = div_q;
    tick    = 1'b0;
`ifdef SINE_AMP_EN
    amp_d   = amp_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          fcw_d   = bus.fcw;
          div_d   = bus.div;
          phase_d = '0;
          count_d = '0;
`ifdef SINE_AMP_EN
          amp_d   = bus.amp;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = DRAIN;
        end else begin
          tick = (count_q == '0);
          if (tick) begin
            count_d = div_q;
            phase_d = phase_q + fcw_q;
          end else begin
            count_d = count_q - DIV_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign quad = phase_q[PHASE_W-1 -: 2];
  assign idx  = phase_q[PHASE_W-3 -: LUT_AW];

  // Odd quadrants read the table mirrored; the upper half-cycle is subtracted from midscale.
  always_comb begin
    s1_valid_d = tick;
    s1_neg_d   = quad[1];
    s1_addr_d  = quad[0] ? ~idx : idx;
    s2_valid_d = s1_valid_q;
    s2_neg_d   = s1_neg_q;
`ifdef SINE_AMP_EN
    s3a_valid_d = s2_valid_q;
    s3a_neg_d   = s2_neg_q;
    s3a_mag_d   = MAG_W'((24'(s2_mag) * 24'(amp_q)) >> 12);
    fin_valid   = s3a_valid_q;
    fin_neg     = s3a_neg_q;
    fin_mag     = s3a_mag_q;
`else
    fin_valid   = s2_valid_q;
    fin_neg     = s2_neg_q;
    fin_mag     = s2_mag;
`endif
    data_valid_d = fin_valid;
    data_out_d   = data_out_q;
    if (fin_valid) begin
      data_out_d = fin_neg ? (MIDSCALE - DATA_W'(fin_mag)) : (MIDSCALE + DATA_W'(fin_mag));
    end
  end

  sine_qlut u_qlut (
    .clk  (clk),
    .addr (s1_addr_q),
    .mag  (s2_mag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      fcw_q        <= '0;
      count_q      <= '0;
      div_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_neg_q     <= 1'b0;
      data_out_q   <= MIDSCALE;
      data_valid_q <= 1'b0;
`ifdef SINE_AMP_EN
      amp_q        <= '0;
      s3a_valid_q  <= 1'b0;
      s3a_neg_q    <= 1'b0;
      s3a_mag_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      fcw_q        <= fcw_d;
      count_q      <= count_d;
      div_q        <= div_d;
      s1_valid_q   <= s1_valid_d;
      s1_neg_q     <= s1_neg_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_neg_q     <= s2_neg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
`ifdef SINE_AMP_EN
      amp_q        <= amp_d;
      s3a_valid_q  <= s3a_valid_d;
      s3a_neg_q    <= s3a_neg_d;
      s3a_mag_q    <= s3a_mag_d;
`endif
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
